// File: rtl/graphics_state_buffer.sv
// Double-buffered game-object state: CPU writes the back bank, render side sees a front bank swapped only at frame end.
// Optional DEMO_ANIM_EN animates front register 0 on frame ends without a swap.
module graphics_state_buffer #(
  parameter int          NUM_REGS   = 10,
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 4,
  parameter int          CS_BIT     = 0,
  parameter logic [18:0] LAST_PIXEL = 19'h4AFFF,
  parameter int          FCNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 chipselect,
  input  logic [DATA_W-1:0]          databus,
  input  logic [ADDR_W-1:0]          data_address,
  input  logic                       VGA_ready,
  input  logic [18:0]                pixel_address,
  output logic [NUM_REGS*DATA_W-1:0] front_regs,
  output logic                       commit_pending,
  output logic                       swap_done,
  output logic                       frame_end,
  output logic [FCNT_W-1:0]          frame_count
);

  localparam logic [ADDR_W-1:0] COMMIT_ADDR = '1;

  logic [DATA_W-1:0] back_q  [NUM_REGS];
  logic [DATA_W-1:0] front_q [NUM_REGS];

  logic wr;
  logic commit_wr;
  logic fe;
  logic swap;
  logic unused_cs;

  assign wr        = chipselect[CS_BIT];
  assign commit_wr = wr && (data_address == COMMIT_ADDR);
  assign fe        = VGA_ready && (pixel_address == LAST_PIXEL);
  assign swap      = fe && commit_pending;
  assign unused_cs = ^chipselect;

  // Addresses between NUM_REGS and COMMIT match no register and fall through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) back_q[i] <= '0;
    end else if (wr) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (data_address == ADDR_W'(i)) back_q[i] <= databus;
    end
  end

  // Swap reads back_q before this edge's write lands, so a colliding write waits for the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) front_q[i] <= '0;
`ifdef DEMO_ANIM_EN
      front_q[0] <= DATA_W'(100);
`endif
    end else if (swap) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) front_q[i] <= back_q[i];
    end
`ifdef DEMO_ANIM_EN
    else if (fe) begin
      front_q[0] <= (front_q[0] <= DATA_W'(400)) ? front_q[0] + DATA_W'(1) : DATA_W'(100);
    end
`endif
  end

  // A commit arriving on the fe edge is held for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
      swap_done      <= 1'b0;
      frame_end      <= 1'b0;
      frame_count    <= '0;
    end else begin
      if (commit_wr)  commit_pending <= 1'b1;
      else if (swap)  commit_pending <= 1'b0;
      swap_done <= swap;
      frame_end <= fe;
      if (fe) frame_count <= frame_count + FCNT_W'(1);
    end
  end

  always_comb begin
    front_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      front_regs[i*DATA_W +: DATA_W] = front_q[i];
  end

endmodule

// File: tb/tb_graphics_state_buffer.sv
// Directed bench for graphics_state_buffer: a spec-level model pushes expected outputs to a scoreboard each cycle.
// Builds with or without DEMO_ANIM_EN.
module tb_graphics_state_buffer;

  localparam int          NR = 10;
  localparam int          DW = 16;
  localparam int          AW = 4;
  localparam int          FW = 8;
  localparam logic [18:0] LP = 19'h4AFFF;
  localparam logic [AW-1:0] CMT = 4'hF;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        chipselect;
  logic [DW-1:0]     databus;
  logic [AW-1:0]     data_address;
  logic              VGA_ready;
  logic [18:0]       pixel_address;
  logic [NR*DW-1:0]  front_regs;
  logic              commit_pending;
  logic              swap_done;
  logic              frame_end;
  logic [FW-1:0]     frame_count;

  graphics_state_buffer #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .CS_BIT(0),
    .LAST_PIXEL(LP), .FCNT_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .databus(databus),
    .data_address(data_address), .VGA_ready(VGA_ready), .pixel_address(pixel_address),
    .front_regs(front_regs), .commit_pending(commit_pending), .swap_done(swap_done),
    .frame_end(frame_end), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    int               sel;
    logic [NR*DW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] back_m  [NR];
  logic [DW-1:0] front_m [NR];
  logic          pend_m;
  logic [FW-1:0] fc_m;

  function automatic logic [NR*DW-1:0] observe(input int sel);
    case (sel)
      0: return front_regs;
      1: return {{(NR*DW-1){1'b0}}, commit_pending};
      2: return {{(NR*DW-1){1'b0}}, swap_done};
      3: return {{(NR*DW-1){1'b0}}, frame_end};
      4: return {{(NR*DW-FW){1'b0}}, frame_count};
      5: return {{(NR*DW-DW){1'b0}}, front_regs[0*DW +: DW]};
      6: return {{(NR*DW-DW){1'b0}}, front_regs[1*DW +: DW]};
      7: return {{(NR*DW-DW){1'b0}}, front_regs[4*DW +: DW]};
      default: return '1;
    endcase
  endfunction

  function automatic logic [NR*DW-1:0] pack_front();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = front_m[i];
    return v;
  endfunction

  function automatic void push(input string tag, input int sel, input logic [NR*DW-1:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endfunction

  task automatic drain();
    exp_t e;
    logic [NR*DW-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic push_state(input string pfx);
    push({pfx, "_front"},   0, pack_front());
    push({pfx, "_pending"}, 1, {{(NR*DW-1){1'b0}}, pend_m});
    push({pfx, "_count"},   4, {{(NR*DW-FW){1'b0}}, fc_m});
  endtask

  task automatic chk(input string tag, input int sel, input logic [NR*DW-1:0] v);
    push(tag, sel, v);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chipselect = '0; databus = '0; data_address = '0; VGA_ready = 1'b0; pixel_address = '0;
    for (int i = 0; i < NR; i++) begin back_m[i] = '0; front_m[i] = '0; end
`ifdef DEMO_ANIM_EN
    front_m[0] = 16'd100;
`endif
    pend_m = 1'b0; fc_m = '0;
    push_state("rst");
    push("rst_swap_done", 2, '0);
    push("rst_frame_end", 3, '0);
    @(posedge clk); #1;
    drain();
    rst = 1'b0;
  endtask

  // One clock with the given bus/pixel inputs; model applies spec rules, then outputs are compared.
  task automatic drive(input string tag, input logic [3:0] cs, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy, input logic [18:0] px);
    logic f, sw, w;
    w  = cs[0];
    f  = rdy && (px == LP);
    sw = f && pend_m;
    chipselect = cs; data_address = a; databus = d; VGA_ready = rdy; pixel_address = px;
    if (sw) begin
      for (int i = 0; i < NR; i++) front_m[i] = back_m[i];
    end
`ifdef DEMO_ANIM_EN
    else if (f) front_m[0] = (front_m[0] <= 16'd400) ? front_m[0] + 16'd1 : 16'd100;
`endif
    if (w && a == CMT) pend_m = 1'b1;
    else if (sw)       pend_m = 1'b0;
    if (w && int'(a) < NR) back_m[a] = d;
    if (f) fc_m = fc_m + 8'd1;
    push_state(tag);
    push({tag, "_swap_done"}, 2, {{(NR*DW-1){1'b0}}, sw});
    push({tag, "_frame_end"}, 3, {{(NR*DW-1){1'b0}}, f});
    @(posedge clk); #1;
    chipselect = '0; VGA_ready = 1'b0; pixel_address = 19'h00100;
    drain();
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(tag, 4'b0001, a, d, 1'b0, 19'h00100);
  endtask

  task automatic fe(input string tag);
    drive(tag, 4'b0000, '0, '0, 1'b1, LP);
  endtask

  task automatic idle(input string tag);
    drive(tag, 4'b0000, '0, '0, 1'b0, 19'h00100);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
`ifndef DEMO_ANIM_EN
    chk("rst_front_zero", 0, '0);
`endif
    fe("fe_first");
    chk("fe_first_count", 4, 1);
`ifndef DEMO_ANIM_EN
    chk("fe_first_front_zero", 0, '0);
`endif

    wr("wr0", 4'd0, 16'd350);
    wr("wr4", 4'd4, 16'd999);
    wr("commit1", CMT, 16'hDEAD);
    chk("commit1_pending", 1, 1);
    idle("hold1");
    fe("swap1");
    chk("swap1_front0", 5, 350);
    chk("swap1_front4", 7, 999);
    chk("swap1_done", 2, 1);
    idle("after_swap1");
    chk("swap1_done_cleared", 2, 0);

    wr("wr1_5", 4'd1, 16'd5);
    wr("commit2", CMT, 16'h0);
    drive("collide", 4'b0001, 4'd1, 16'd7, 1'b1, LP);
    chk("collide_front1", 6, 5);
    wr("commit3", CMT, 16'h0);
    fe("swap3");
    chk("swap3_front1", 6, 7);

    wr("wr2", 4'd2, 16'h0022);
    drive("commit_fe", 4'b0001, CMT, 16'h0, 1'b1, LP);
    chk("commit_fe_pending", 1, 1);
    chk("commit_fe_no_swap", 2, 0);
    wr("commit_rep", CMT, 16'h1);
    drive("near_px", 4'b0000, '0, '0, 1'b1, LP - 19'd1);
    drive("not_ready", 4'b0000, '0, '0, 1'b0, LP);
    fe("swap4");
    chk("swap4_pending_clear", 1, 0);

    wr("oob12", 4'd12, 16'hBEEF);
    wr("oob14", 4'd14, 16'hCAFE);
    drive("wrong_cs", 4'b1110, 4'd3, 16'h3333, 1'b0, 19'h00100);
    wr("commit5", CMT, 16'h0);
    fe("swap5");
    idle("post5");

    do_reset();
    for (int n = 0; n < 256; n++) fe("wrap");
    chk("wrap_count_zero", 4, 0);

`ifdef DEMO_ANIM_EN
    do_reset();
    chk("anim_rst_100", 5, 100);
    for (int n = 0; n < 301; n++) fe("anim");
    chk("anim_401", 5, 401);
    fe("anim_reload");
    chk("anim_reload_100", 5, 100);
    fe("anim_more");
    fe("anim_more");
    do_reset();
    chk("anim_mid_rst_100", 5, 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
